// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter for the shared serial bus between master 1 and
//   master 2. The bus is granted only while every slave reports ready.
//   Ownership is held until the owner drops breq. After that, one dead
//   HANDOVER cycle follows before requests are looked at again.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   - an owner that holds the bus for TIMEOUT_CYCLES cycles is
//                 preempted and timeout pulses for one cycle.
//     undefined - no hold counter; an owner keeps the bus indefinitely.
//
// Ports
//   clk        in   bus clock (rising edge)
//   rstn       in   asynchronous active-low reset
//   m1_breq    in   master 1 bus request
//   m2_breq    in   master 2 bus request
//   s_ready    in   AND of slave ready flags; gates new grants only
//   m1_bgrant  out  master 1 owns the bus
//   m2_bgrant  out  master 2 owns the bus
//   m1_ack     out  one-cycle pulse on the first cycle of an m1 grant
//   m2_ack     out  one-cycle pulse on the first cycle of an m2 grant
//   msel       out  bus mux select (0 = m1, 1 = m2); keeps last owner
//   busy       out  high in GRANT and HANDOVER
//   timeout    out  one-cycle preemption pulse (tied 0 without the macro)
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic s_ready,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic m1_ack,
  output logic m2_ack,
  output logic msel,
  output logic busy,
  output logic timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("bus_arbiter_rr: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic m1_bgrant_q, m1_bgrant_d;
  logic m2_bgrant_q, m2_bgrant_d;
  logic m1_ack_q, m1_ack_d;
  logic m2_ack_q, m2_ack_d;
  logic msel_q, msel_d;
  logic busy_q, busy_d;
  // 0 = master 1, 1 = master 2; resets to master 2 so master 1 wins the first tie
  logic last_owner_q, last_owner_d;

  logic winner;     // 0 = master 1, 1 = master 2
  logic owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    m1_bgrant_d  = 1'b0;
    m2_bgrant_d  = 1'b0;
    m1_ack_d     = 1'b0;
    m2_ack_d     = 1'b0;
    msel_d       = msel_q;
    last_owner_d = last_owner_q;
    winner       = 1'b0;
    // During GRANT msel_q identifies the owner
    owner_req    = msel_q ? m2_breq : m1_breq;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (s_ready && (m1_breq || m2_breq)) begin
          // Tie goes to whoever did not own the bus last
          winner       = (m1_breq && m2_breq) ? ~last_owner_q : m2_breq;
          state_d      = GRANT;
          m1_bgrant_d  = ~winner;
          m2_bgrant_d  = winner;
          m1_ack_d     = ~winner;
          m2_ack_d     = winner;
          msel_d       = winner;
          last_owner_d = winner;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d   = '0;
`endif
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // Release takes priority over a simultaneous timeout: no pulse
          state_d = HANDOVER;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_MAX) begin
          // Preempted owner stays last_owner so the other master wins a tie
          state_d   = HANDOVER;
          timeout_d = 1'b1;
        end
`endif
        else begin
          m1_bgrant_d = ~msel_q;
          m2_bgrant_d = msel_q;
`ifdef ARB_TIMEOUT_EN
          // Cannot pass HOLD_MAX: reaching it forces HANDOVER above
          hold_cnt_d  = hold_cnt_q + 1'b1;
`endif
        end
      end

      HANDOVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      m1_bgrant_q  <= 1'b0;
      m2_bgrant_q  <= 1'b0;
      m1_ack_q     <= 1'b0;
      m2_ack_q     <= 1'b0;
      msel_q       <= 1'b0;
      busy_q       <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      m1_bgrant_q  <= m1_bgrant_d;
      m2_bgrant_q  <= m2_bgrant_d;
      m1_ack_q     <= m1_ack_d;
      m2_ack_q     <= m2_ack_d;
      msel_q       <= msel_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign m1_bgrant = m1_bgrant_q;
  assign m2_bgrant = m2_bgrant_q;
  assign m1_ack    = m1_ack_q;
  assign m2_ack    = m2_ack_q;
  assign msel      = msel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Bench for bus_arbiter_rr. A driver issues request rounds. For each
//   round it predicts which master should own the bus, from which cycle and
//   for how long, and pushes that into a scoreboard. A monitor pops an
//   entry whenever the DUT raises an ack. It then follows the grant, busy,
//   msel and timeout outputs against that entry, one cycle at a time.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  logic m1_breq, m2_breq, s_ready;
  logic m1_bgrant, m2_bgrant, m1_ack, m2_ack, msel, busy, timeout;

  bus_arbiter_rr #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m1_breq  (m1_breq),
    .m2_breq  (m2_breq),
    .s_ready  (s_ready),
    .m1_bgrant(m1_bgrant),
    .m2_bgrant(m2_bgrant),
    .m1_ack   (m1_ack),
    .m2_ack   (m2_ack),
    .msel     (msel),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; a grant decided at edge N is seen at the
  // following falling edge with cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;     // 1 or 2
    int start;  // cycle of the grant decision edge
    int len;    // grant cycles
    bit to;     // ends in preemption
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   last_owner = 2;  // reference model: master that owned the bus last

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic void push_exp(int id, int start, int len, bit to);
    exp_t e;
    e.id    = id;
    e.start = start;
    e.len   = len;
    e.to    = to;
    sb.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  exp_t cur;
  bit   act      = 1'b0;
  int   msel_exp = 0;

  always @(negedge clk or negedge rstn) begin
    int id;
    int g_end;
    if (!rstn) begin
      act      = 1'b0;
      msel_exp = 0;
      sb.delete();
    end else begin
      chk("grant_mutex", int'(m1_bgrant & m2_bgrant), 0);
      if (m1_ack || m2_ack) begin
        id = m1_ack ? 1 : 2;
        chk("ack_onehot", int'(m1_ack & m2_ack), 0);
        if (sb.size() == 0) begin
          chk("ack_unexpected_master", id, 0);
        end else begin
          cur = sb.pop_front();
          chk("ack_master", id, cur.id);
          chk("ack_cycle", cyc, cur.start);
          act      = 1'b1;
          msel_exp = (cur.id == 2) ? 1 : 0;
        end
      end
      g_end = cur.start + cur.len;
      chk("m1_bgrant", int'(m1_bgrant), int'(act && cur.id == 1 && cyc < g_end));
      chk("m2_bgrant", int'(m2_bgrant), int'(act && cur.id == 2 && cyc < g_end));
      chk("busy", int'(busy), int'(act && cyc <= g_end));
      chk("timeout", int'(timeout), int'(act && cur.to && cyc == g_end));
      chk("msel", int'(msel), msel_exp);
      if (act && cyc >= g_end) act = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic go_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_req(int id, logic v);
    if (id == 1) m1_breq = v;
    else         m2_breq = v;
  endtask

  // Keep the owner's request up until the drop cycle. s_ready toggles
  // randomly meanwhile, since it must not matter during a grant.
  task automatic hold(int id, int drop_c);
    while (cyc < drop_c) begin
      s_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    s_ready = 1'b1;
    set_req(id, 1'b0);
  endtask

  // mode 0: m1 only, 1: m2 only, 2: both together,
  //      3: m1 then m2 during grant, 4: m2 then m1 during grant.
  // Starts and ends on a falling edge with the arbiter idle.
  task automatic round(int mode, int stall, int l1, int l2);
    int c, w, o, st, st2, rel;
    bit other;
    c     = cyc;
    other = (mode >= 2);
    case (mode)
      0, 3:    w = 1;
      1, 4:    w = 2;
      default: w = (last_owner == 1) ? 2 : 1;
    endcase
    o   = 3 - w;
    st  = c + stall + 1;
    st2 = st + l1 + 2;  // release edge, dead cycle, then decision edge
    push_exp(w, st, l1, 1'b0);
    last_owner = w;
    if (other) begin
      push_exp(o, st2, l2, 1'b0);
      last_owner = o;
    end
    rel = other ? st2 + l2 : st + l1;

    s_ready = (stall == 0);
    set_req(w, 1'b1);
    if (mode == 2) set_req(o, 1'b1);
    repeat (stall) @(negedge clk);
    s_ready = 1'b1;
    @(negedge clk);
    if (mode >= 3) set_req(o, 1'b1);
    hold(w, st + l1 - 1);
    if (other) begin
      go_cyc(st2);
      hold(o, st2 + l2 - 1);
    end
    go_cyc(rel + 1);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_m1_bgrant"}, int'(m1_bgrant), 0);
    chk({tag, "_m2_bgrant"}, int'(m2_bgrant), 0);
    chk({tag, "_m1_ack"},    int'(m1_ack),    0);
    chk({tag, "_m2_ack"},    int'(m2_ack),    0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_timeout"},   int'(timeout),   0);
    chk({tag, "_msel"},      int'(msel),      0);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic timeout_tests();
    int st, st2, st3;
    // m1 holds, m2 waiting: preempt, m2 served, then m1 again
    st  = cyc + 1;
    st2 = st + TO + 2;
    st3 = st2 + 3 + 2;
    push_exp(1, st, TO, 1'b1);
    push_exp(2, st2, 3, 1'b0);
    push_exp(1, st3, 2, 1'b0);
    last_owner = 1;
    s_ready = 1'b1;
    m1_breq = 1'b1;
    @(negedge clk);
    m2_breq = 1'b1;
    go_cyc(st2 + 2);
    m2_breq = 1'b0;
    go_cyc(st3 + 1);
    m1_breq = 1'b0;
    go_cyc(st3 + 3);
    // lone owner is preempted and then granted again
    st  = cyc + 1;
    st2 = st + TO + 2;
    push_exp(1, st, TO, 1'b1);
    push_exp(1, st2, 2, 1'b0);
    m1_breq = 1'b1;
    go_cyc(st2 + 1);
    m1_breq = 1'b0;
    go_cyc(st2 + 3);
  endtask
`endif

  initial begin
    int st;
    rstn    = 1'b0;
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    s_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rstn = 1'b1;
    @(negedge clk);

    round(0, 0, 3, 0);                 // first grant after reset
    repeat (4) round(2, 0, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    round(3, 0, 4, 3);                 // handover to a waiting master
    round(1, 10, 3, 0);                // stalled by s_ready for 10 cycles
    round(2, 3, 2, 2);
`ifdef ARB_TIMEOUT_EN
    round(3, 0, TO, 2);                // release on the timeout cycle: no pulse
    timeout_tests();
`else
    round(3, 0, 120, 2);               // no preemption without the feature
`endif
    repeat (40) round(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(1, TO)), int'($urandom_range(1, TO)));

    // reset in the middle of an m2 grant
    st = cyc + 1;
    push_exp(2, st, 1000, 1'b0);
    s_ready = 1'b1;
    m2_breq = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 reset_checks("midreset");
    m2_breq    = 1'b0;
    last_owner = 2;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    round(2, 0, 2, 2);                 // tie after reset: m1 first

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
